// File: rtl/sd_sector_buffer.sv
// Ping-pong sector buffer between the SD SPI reader and a valid/ready byte consumer.
// Also generates the address of the next sector and holds it back while both banks are occupied.
module sd_sector_buffer #(
  parameter logic [23:0] StartAddress = 24'h000000,
  parameter int unsigned SectorBytes  = 512
) (
  input  logic        MasterCLK,
  input  logic        Reset,
  input  logic [7:0]  SD_Data,
  input  logic        SD_DataEnable,
  input  logic        SD_DataClock,
  output logic [23:0] SD_Address,
  output logic [7:0]  Out_Data,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic        BanksFull,
  output logic        Overflow,
  output logic        ShortSector
);

  localparam int unsigned AW = $clog2(SectorBytes);
  localparam logic [23:0] SectorStep = 24'(SectorBytes);

  typedef enum logic [1:0] {WR_IDLE, WR_FILL, WR_DROP} wr_state_e;

  // [1:0] two-stage synchronizer, [2] previous synchronized level for edge detect
  logic [2:0]    sclk_q;
  logic          tick;

  wr_state_e     wr_state_q;
  logic          wr_bank_q;
  logic [AW:0]   wr_cnt_q;
  logic [1:0]    full_q;
  logic [23:0]   addr_q;
  logic          overflow_q;
  logic          short_q;

  logic          rd_bank_q;
  logic [AW:0]   rd_idx_q;
  logic [AW-1:0] drain_cnt_q;
  logic [7:0]    out_data_q;
  logic          out_valid_q;
  logic [7:0]    skid_data_q;
  logic          skid_valid_q;

  logic [7:0]    mem_q [0:2*SectorBytes-1];
  logic          wr_en;
  logic [AW:0]   wr_addr;
  logic [AW:0]   rd_addr;
  logic [7:0]    rd_data;
  logic          issue;
  logic          take;
  logic          bank_done;

  assign tick = sclk_q[1] & ~sclk_q[2];

  always_ff @(posedge MasterCLK) begin
    if (Reset) sclk_q <= 3'b000;
    else       sclk_q <= {sclk_q[1:0], SD_DataClock};
  end

  // Write count is held at zero outside FILL, so it doubles as the RAM index
  assign wr_addr = {wr_bank_q, wr_cnt_q[AW-1:0]};

  always_comb begin
    wr_en = 1'b0;
    if (tick && SD_DataEnable) begin
      if (wr_state_q == WR_IDLE)      wr_en = ~full_q[wr_bank_q];
      else if (wr_state_q == WR_FILL) wr_en = ~wr_cnt_q[AW];
    end
  end

  always_ff @(posedge MasterCLK) begin
    if (wr_en) mem_q[wr_addr] <= SD_Data;
  end

  always_ff @(posedge MasterCLK) begin
    if (Reset) begin
      wr_state_q <= WR_IDLE;
      wr_bank_q  <= 1'b0;
      wr_cnt_q   <= '0;
      full_q     <= 2'b00;
      addr_q     <= StartAddress;
      overflow_q <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      if (bank_done) full_q[rd_bank_q] <= 1'b0;
      if (tick) begin
        case (wr_state_q)
          WR_IDLE: begin
            if (SD_DataEnable) begin
              if (!full_q[wr_bank_q]) begin
                wr_cnt_q   <= {{AW{1'b0}}, 1'b1};
                wr_state_q <= WR_FILL;
              end else begin
                overflow_q <= 1'b1;
                wr_state_q <= WR_DROP;
              end
            end
          end
          WR_FILL: begin
            if (SD_DataEnable) begin
              if (!wr_cnt_q[AW]) wr_cnt_q <= wr_cnt_q + {{AW{1'b0}}, 1'b1};
            end else begin
              wr_state_q <= WR_IDLE;
              wr_cnt_q   <= '0;
              if (wr_cnt_q[AW]) begin
                full_q[wr_bank_q] <= 1'b1;
                wr_bank_q         <= ~wr_bank_q;
                addr_q            <= addr_q + SectorStep;
              end else begin
                short_q <= 1'b1;
              end
            end
          end
          WR_DROP: begin
            if (!SD_DataEnable) wr_state_q <= WR_IDLE;
          end
          default: wr_state_q <= WR_IDLE;
        endcase
      end
    end
  end

  // Reads are issued only while the skid is empty, so a stalled consumer
  // never has more than one byte in flight behind the output register.
  assign rd_addr   = {rd_bank_q, rd_idx_q[AW-1:0]};
  assign rd_data   = mem_q[rd_addr];
  assign issue     = full_q[rd_bank_q] & ~rd_idx_q[AW] & ~skid_valid_q;
  assign take      = out_valid_q & Out_Ready;
  assign bank_done = take & (drain_cnt_q == {AW{1'b1}});

  always_ff @(posedge MasterCLK) begin
    if (Reset) begin
      rd_bank_q    <= 1'b0;
      rd_idx_q     <= '0;
      drain_cnt_q  <= '0;
      out_data_q   <= 8'h00;
      out_valid_q  <= 1'b0;
      skid_data_q  <= 8'h00;
      skid_valid_q <= 1'b0;
    end else begin
      if (issue) rd_idx_q <= rd_idx_q + {{AW{1'b0}}, 1'b1};
      if (take) begin
        if (bank_done) begin
          drain_cnt_q <= '0;
          rd_bank_q   <= ~rd_bank_q;
          rd_idx_q    <= '0;
        end else begin
          drain_cnt_q <= drain_cnt_q + {{(AW-1){1'b0}}, 1'b1};
        end
      end
      if (take || !out_valid_q) begin
        if (skid_valid_q) begin
          out_data_q   <= skid_data_q;
          out_valid_q  <= 1'b1;
          skid_valid_q <= 1'b0;
        end else begin
          out_valid_q <= issue;
          if (issue) out_data_q <= rd_data;
        end
      end else if (issue) begin
        skid_data_q  <= rd_data;
        skid_valid_q <= 1'b1;
      end
    end
  end

  assign SD_Address  = addr_q;
  assign Out_Data    = out_data_q;
  assign Out_Valid   = out_valid_q;
  assign BanksFull   = &full_q;
  assign Overflow    = overflow_q;
  assign ShortSector = short_q;

endmodule

// File: tb/tb_sd_sector_buffer.sv
// Directed bench for sd_sector_buffer: a queue-based model of accepted sectors
// checks every output handshake, plus literal checks of addresses and flags.
module tb_sd_sector_buffer;
  localparam int SB = 512;

  logic        MasterCLK = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  SD_Data = 8'h00;
  logic        SD_DataEnable = 1'b0;
  logic        SD_DataClock = 1'b0;
  logic        Out_Ready = 1'b0;
  logic [23:0] SD_Address;
  logic [7:0]  Out_Data;
  logic        Out_Valid, BanksFull, Overflow, ShortSector;
  logic [23:0] w_addr;
  logic [7:0]  w_data;
  logic        w_valid, w_full, w_ovf, w_short;

  int tests = 0;
  int fails = 0;
  int ready_mode = 0;  // 0: never ready, 1: always ready, 2: pseudo-random

  // Model state
  logic [7:0]  exp_q[$];
  logic [23:0] m_addr = 24'h000000;
  logic        m_ovf = 1'b0;
  logic        m_short = 1'b0;
  int          m_committed = 0;
  int          m_released = 0;
  int          hs_mod = 0;

  always #5 MasterCLK = ~MasterCLK;

  sd_sector_buffer #(.StartAddress(24'h000000), .SectorBytes(SB)) dut (
    .MasterCLK(MasterCLK), .Reset(Reset), .SD_Data(SD_Data),
    .SD_DataEnable(SD_DataEnable), .SD_DataClock(SD_DataClock),
    .SD_Address(SD_Address), .Out_Data(Out_Data), .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready), .BanksFull(BanksFull), .Overflow(Overflow),
    .ShortSector(ShortSector));

  sd_sector_buffer #(.StartAddress(24'hFFFE00), .SectorBytes(SB)) u_wrap (
    .MasterCLK(MasterCLK), .Reset(Reset), .SD_Data(SD_Data),
    .SD_DataEnable(SD_DataEnable), .SD_DataClock(SD_DataClock),
    .SD_Address(w_addr), .Out_Data(w_data), .Out_Valid(w_valid),
    .Out_Ready(Out_Ready), .BanksFull(w_full), .Overflow(w_ovf),
    .ShortSector(w_short));

  always @(posedge MasterCLK) begin
    #1;
    case (ready_mode)
      1:       Out_Ready = 1'b1;
      2:       Out_Ready = 1'($urandom_range(0, 1));
      default: Out_Ready = 1'b0;
    endcase
  end

  // Output stream checker: every handshake against the model queue, plus stall hold
  logic       pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = 8'h00;
  always @(negedge MasterCLK) begin
    logic [7:0] e;
    if (Reset) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        tests++;
        if (!Out_Valid || Out_Data !== pd) begin
          fails++;
          $display("FAIL hold: valid=%0b data=0x%02h, required valid=1 data=0x%02h", Out_Valid, Out_Data, pd);
        end
      end
      if (Out_Valid && Out_Ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL stream: unexpected byte 0x%02h, required none", Out_Data);
        end else begin
          e = exp_q.pop_front();
          if (Out_Data !== e) begin
            fails++;
            $display("FAIL stream: got 0x%02h, required 0x%02h", Out_Data, e);
          end
        end
        hs_mod++;
        if (hs_mod == SB) begin
          hs_mod = 0;
          m_released++;
        end
      end
      pv = Out_Valid; pr = Out_Ready; pd = Out_Data;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge MasterCLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic en);
    SD_Data = d;
    SD_DataEnable = en;
    cyc(8);
    SD_DataClock = 1'b1;
    cyc(8);
    SD_DataClock = 1'b0;
  endtask

  // n payload bytes (bytes past SB are 8'hAA), then the enable-low strobe
  task automatic sector(input int n, input logic [7:0] seed);
    logic acc;
    acc = (m_committed - m_released) < 2;
    if (!acc) m_ovf = 1'b1;
    else if (n < SB) m_short = 1'b1;
    else begin
      for (int i = 0; i < SB; i++) exp_q.push_back(seed + 8'(i));
      m_committed++;
      m_addr = m_addr + 24'(SB);
    end
    for (int i = 0; i < n; i++) send_byte((i < SB) ? seed + 8'(i) : 8'hAA, 1'b1);
    send_byte(8'h00, 1'b0);
    cyc(6);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cyc(1);
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d bytes still outstanding, required 0", exp_q.size());
    end
    cyc(4);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_addr = 24'h000000;
    m_ovf = 1'b0;
    m_short = 1'b0;
    m_committed = 0;
    m_released = 0;
    hs_mod = 0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    SD_DataEnable = 1'b0;
    SD_DataClock = 1'b0;
    cyc(3);
    model_reset();
    Reset = 1'b0;
    cyc(4);
  endtask

  task automatic checkpoint(input string tag);
    chk({tag, "_addr"}, 32'(SD_Address), 32'(m_addr));
    chk({tag, "_ovf"}, 32'(Overflow), 32'(m_ovf));
    chk({tag, "_short"}, 32'(ShortSector), 32'(m_short));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(3);
    Reset = 1'b0;
    cyc(2);
    chk("rst_addr", 32'(SD_Address), 32'h000000);
    chk("rst_valid", 32'(Out_Valid), 32'h0);
    chk("rst_data", 32'(Out_Data), 32'h00);
    chk("rst_full", 32'(BanksFull), 32'h0);
    chk("rst_ovf", 32'(Overflow), 32'h0);
    chk("rst_short", 32'(ShortSector), 32'h0);
    chk("rst_wrap_addr", 32'(w_addr), 32'hFFFE00);

    // One 513-byte sector, consumer always ready
    ready_mode = 1;
    sector(513, 8'h00);
    wait_drain(3000);
    chk("t1_addr", 32'(SD_Address), 32'h000200);
    chk("t1_short", 32'(ShortSector), 32'h0);
    chk("t1_wrap_addr", 32'(w_addr), 32'h000000);
    checkpoint("t1");

    // Two sectors stalled, third overflows
    do_reset();
    ready_mode = 0;
    sector(512, 8'h10);
    chk("t2_full_one", 32'(BanksFull), 32'h0);
    sector(512, 8'h55);
    chk("t2_full_two", 32'(BanksFull), 32'h1);
    chk("t2_addr_two", 32'(SD_Address), 32'h000400);
    sector(512, 8'h99);
    chk("t2_ovf", 32'(Overflow), 32'h1);
    chk("t2_addr_three", 32'(SD_Address), 32'h000400);
    checkpoint("t2");
    ready_mode = 1;
    wait_drain(4000);
    chk("t2_full_after", 32'(BanksFull), 32'h0);
    chk("t2_valid_after", 32'(Out_Valid), 32'h0);

    // Short sector
    sector(100, 8'h40);
    chk("t3_short", 32'(ShortSector), 32'h1);
    chk("t3_addr", 32'(SD_Address), 32'h000400);
    chk("t3_valid", 32'(Out_Valid), 32'h0);
    checkpoint("t3");

    // Random back-pressure during drain
    ready_mode = 2;
    sector(512, 8'h33);
    wait_drain(8000);
    ready_mode = 1;
    chk("t4_addr", 32'(SD_Address), 32'h000600);
    checkpoint("t4");

    // Reset in the middle of byte 300
    for (int i = 0; i < 299; i++) send_byte(8'(i), 1'b1);
    SD_Data = 8'(299);
    SD_DataEnable = 1'b1;
    cyc(8);
    SD_DataClock = 1'b1;
    cyc(4);
    Reset = 1'b1;
    SD_DataEnable = 1'b0;
    SD_DataClock = 1'b0;
    cyc(1);
    chk("t6_valid", 32'(Out_Valid), 32'h0);
    chk("t6_data", 32'(Out_Data), 32'h00);
    chk("t6_addr", 32'(SD_Address), 32'h000000);
    chk("t6_full", 32'(BanksFull), 32'h0);
    chk("t6_ovf", 32'(Overflow), 32'h0);
    chk("t6_short", 32'(ShortSector), 32'h0);
    chk("t6_wrap_addr", 32'(w_addr), 32'hFFFE00);
    cyc(2);
    model_reset();
    Reset = 1'b0;
    cyc(4);
    sector(512, 8'h77);
    wait_drain(3000);
    chk("t6_addr_after", 32'(SD_Address), 32'h000200);
    checkpoint("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
